// File: rtl/mem_pipe_stage_regs_if.sv
// Bundle between the MEM1 stage, the MEM-to-WB pipeline registers and write-back.
// Forwarding query signals exist only when MEM_PIPE_FORWARD_EN is defined.
interface mem_pipe_stage_regs_if #(
  parameter int unsigned DATA_WIDTH        = 64,
  parameter int unsigned REG_INDEX_BITS    = 5,
  parameter int unsigned THREAD_INDEX_BITS = 3,
  parameter int unsigned STAGES            = 2
);
  localparam int unsigned OccWidth = $clog2(STAGES + 1);

  logic                         in_valid;
  logic                         in_write_back_flag;
  logic                         in_load_word_flag;
  logic [REG_INDEX_BITS-1:0]    in_reg_index;
  logic [THREAD_INDEX_BITS-1:0] in_thread_index;
  logic [DATA_WIDTH-1:0]        in_reg_data;
  logic [DATA_WIDTH-1:0]        in_bram_data;
  logic                         stall;
  logic                         flush;
  logic [THREAD_INDEX_BITS-1:0] flush_thread_index;

  logic                         out_valid;
  logic                         out_write_back_flag;
  logic                         out_load_word_flag;
  logic [REG_INDEX_BITS-1:0]    out_reg_index;
  logic [THREAD_INDEX_BITS-1:0] out_thread_index;
  logic [DATA_WIDTH-1:0]        out_wb_data;
  logic [OccWidth-1:0]          out_occupancy;

`ifdef MEM_PIPE_FORWARD_EN
  logic [THREAD_INDEX_BITS-1:0] fwd_thread_index;
  logic [REG_INDEX_BITS-1:0]    fwd_reg_index;
  logic                         fwd_hit;
  logic [DATA_WIDTH-1:0]        fwd_data;
`endif

  modport master (
`ifdef MEM_PIPE_FORWARD_EN
    output fwd_thread_index, fwd_reg_index,
    input  fwd_hit, fwd_data,
`endif
    output in_valid, in_write_back_flag, in_load_word_flag, in_reg_index, in_thread_index,
    output in_reg_data, in_bram_data, stall, flush, flush_thread_index,
    input  out_valid, out_write_back_flag, out_load_word_flag, out_reg_index,
    input  out_thread_index, out_wb_data, out_occupancy
  );

  modport slave (
`ifdef MEM_PIPE_FORWARD_EN
    input  fwd_thread_index, fwd_reg_index,
    output fwd_hit, fwd_data,
`endif
    input  in_valid, in_write_back_flag, in_load_word_flag, in_reg_index, in_thread_index,
    input  in_reg_data, in_bram_data, stall, flush, flush_thread_index,
    output out_valid, out_write_back_flag, out_load_word_flag, out_reg_index,
    output out_thread_index, out_wb_data, out_occupancy
  );
endinterface

// File: rtl/mem_pipe_stage_regs.sv
// MEM1-to-write-back register chain with BRAM result alignment, stall, per-thread flush and
// occupancy. Defining MEM_PIPE_FORWARD_EN adds a combinational register-forwarding lookup.
module mem_pipe_stage_regs #(
  parameter int unsigned DATA_WIDTH        = 64,
  parameter int unsigned REG_INDEX_BITS    = 5,
  parameter int unsigned THREAD_INDEX_BITS = 3,
  parameter int unsigned STAGES            = 2,
  parameter int unsigned BRAM_LATENCY      = 1
) (
  input logic                  clk,
  input logic                  reset,
  mem_pipe_stage_regs_if.slave bus
);
  localparam int unsigned OccWidth = $clog2(STAGES + 1);
  localparam int unsigned BramIdx  = BRAM_LATENCY - 1;
  localparam int unsigned OutIdx   = STAGES - 1;

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            wb_q, wb_d;
  logic [STAGES-1:0]            load_q, load_d;
  logic [STAGES-1:0]            held_q, held_d;
  logic [REG_INDEX_BITS-1:0]    reg_q  [STAGES];
  logic [REG_INDEX_BITS-1:0]    reg_d  [STAGES];
  logic [THREAD_INDEX_BITS-1:0] thr_q  [STAGES];
  logic [THREAD_INDEX_BITS-1:0] thr_d  [STAGES];
  logic [DATA_WIDTH-1:0]        data_q [STAGES];
  logic [DATA_WIDTH-1:0]        data_d [STAGES];
  logic [OccWidth-1:0]          occ_q, occ_d;

  logic [STAGES-1:0]     flush_hit;
  logic                  in_kill;
  logic [DATA_WIDTH-1:0] bram_sel;

  always_comb begin
    in_kill = bus.flush && (bus.in_thread_index == bus.flush_thread_index);
    for (int unsigned k = 0; k < STAGES; k++) begin
      flush_hit[k] = bus.flush && (thr_q[k] == bus.flush_thread_index);
    end
    // Once a stall has captured the BRAM word, the live BRAM port no longer belongs to us.
    bram_sel = held_q[BramIdx] ? data_q[BramIdx] : bus.in_bram_data;
  end

  always_comb begin
    valid_d = valid_q;
    wb_d    = wb_q;
    load_d  = load_q;
    held_d  = held_q;
    reg_d   = reg_q;
    thr_d   = thr_q;
    data_d  = data_q;

    if (bus.stall) begin
      valid_d = valid_q & ~flush_hit;
      if (valid_q[BramIdx] && load_q[BramIdx] && !held_q[BramIdx]) begin
        data_d[BramIdx] = bus.in_bram_data;
        held_d[BramIdx] = 1'b1;
      end
    end else begin
      held_d    = '0;
      valid_d[0] = bus.in_valid && !in_kill;
      wb_d[0]    = bus.in_write_back_flag;
      load_d[0]  = bus.in_load_word_flag;
      reg_d[0]   = bus.in_reg_index;
      thr_d[0]   = bus.in_thread_index;
      data_d[0]  = bus.in_reg_data;
      for (int unsigned k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1] && !flush_hit[k-1];
        wb_d[k]    = wb_q[k-1];
        load_d[k]  = load_q[k-1];
        reg_d[k]   = reg_q[k-1];
        thr_d[k]   = thr_q[k-1];
        if ((k - 1 == BramIdx) && valid_q[k-1] && load_q[k-1]) begin
          data_d[k] = bram_sel;
        end else begin
          data_d[k] = data_q[k-1];
        end
      end
    end

    occ_d = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      occ_d = occ_d + OccWidth'(valid_d[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      wb_q    <= '0;
      load_q  <= '0;
      held_q  <= '0;
      occ_q   <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        reg_q[k]  <= '0;
        thr_q[k]  <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wb_q    <= wb_d;
      load_q  <= load_d;
      held_q  <= held_d;
      occ_q   <= occ_d;
      reg_q   <= reg_d;
      thr_q   <= thr_d;
      data_q  <= data_d;
    end
  end

  assign bus.out_valid           = valid_q[OutIdx];
  assign bus.out_write_back_flag = valid_q[OutIdx] & wb_q[OutIdx];
  assign bus.out_load_word_flag  = load_q[OutIdx];
  assign bus.out_reg_index       = reg_q[OutIdx];
  assign bus.out_thread_index    = thr_q[OutIdx];
  assign bus.out_occupancy       = occ_q;

  // When the BRAM answers in the last slot, the load result bypasses the registers.
  assign bus.out_wb_data = ((BRAM_LATENCY == STAGES) && load_q[OutIdx] && !held_q[OutIdx]) ?
                           bus.in_bram_data : data_q[OutIdx];

`ifdef MEM_PIPE_FORWARD_EN
  logic                  fwd_found;
  logic                  fwd_final;
  logic [DATA_WIDTH-1:0] fwd_word;

  // Scan oldest to youngest so the youngest match overrides, including its finality.
  always_comb begin
    fwd_found = 1'b0;
    fwd_final = 1'b0;
    fwd_word  = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      if (valid_q[k] && wb_q[k] && (thr_q[k] == bus.fwd_thread_index) &&
          (reg_q[k] == bus.fwd_reg_index)) begin
        fwd_found = 1'b1;
        fwd_final = !load_q[k] || (k > int'(BramIdx)) || held_q[k];
        fwd_word  = data_q[k];
      end
    end
  end

  assign bus.fwd_hit  = !reset && fwd_found && fwd_final;
  assign bus.fwd_data = bus.fwd_hit ? fwd_word : '0;
`endif
endmodule

// File: tb/tb_mem_pipe_stage_regs.sv
// Directed bench for mem_pipe_stage_regs (STAGES=2, BRAM_LATENCY=1): vector table plus
// stall, flush, async reset and optional forwarding sequences.
module tb_mem_pipe_stage_regs;
  localparam int unsigned DW = 64;
  localparam int unsigned RW = 5;
  localparam int unsigned TW = 3;
  localparam int unsigned ST = 2;
  localparam int unsigned BL = 1;
  localparam int unsigned NV = 10;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_pipe_stage_regs_if #(
    .DATA_WIDTH(DW), .REG_INDEX_BITS(RW), .THREAD_INDEX_BITS(TW), .STAGES(ST)
  ) bus ();

  mem_pipe_stage_regs #(
    .DATA_WIDTH(DW), .REG_INDEX_BITS(RW), .THREAD_INDEX_BITS(TW), .STAGES(ST),
    .BRAM_LATENCY(BL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v, wb, ld;
    logic [RW-1:0] ri;
    logic [TW-1:0] ti;
    logic [DW-1:0] rd, bd;
    logic          e_v, e_wb, e_ld;
    logic [RW-1:0] e_ri;
    logic [TW-1:0] e_ti;
    logic [DW-1:0] e_d;
    logic [1:0]    e_occ;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic v, wb, ld, input logic [RW-1:0] ri,
                              input logic [TW-1:0] ti, input logic [DW-1:0] rd, bd,
                              input logic e_v, e_wb, e_ld, input logic [RW-1:0] e_ri,
                              input logic [TW-1:0] e_ti, input logic [DW-1:0] e_d,
                              input logic [1:0] e_occ);
    vec_t r;
    r.v = v; r.wb = wb; r.ld = ld; r.ri = ri; r.ti = ti; r.rd = rd; r.bd = bd;
    r.e_v = e_v; r.e_wb = e_wb; r.e_ld = e_ld; r.e_ri = e_ri; r.e_ti = e_ti;
    r.e_d = e_d; r.e_occ = e_occ;
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_v, e_wb, e_ld, input logic [RW-1:0] e_ri,
                         input logic [TW-1:0] e_ti, input logic [DW-1:0] e_d,
                         input logic [1:0] e_occ);
    chk({tag, ".valid"}, DW'(bus.out_valid), DW'(e_v));
    chk({tag, ".wb"}, DW'(bus.out_write_back_flag), DW'(e_wb));
    chk({tag, ".load"}, DW'(bus.out_load_word_flag), DW'(e_ld));
    chk({tag, ".reg"}, DW'(bus.out_reg_index), DW'(e_ri));
    chk({tag, ".thread"}, DW'(bus.out_thread_index), DW'(e_ti));
    chk({tag, ".data"}, bus.out_wb_data, e_d);
    chk({tag, ".occ"}, DW'(bus.out_occupancy), DW'(e_occ));
  endtask

  task automatic chk_vo(input string tag, input logic e_v, input logic [1:0] e_occ);
    chk({tag, ".valid"}, DW'(bus.out_valid), DW'(e_v));
    chk({tag, ".occ"}, DW'(bus.out_occupancy), DW'(e_occ));
  endtask

  task automatic drive(input logic v, wb, ld, input logic [RW-1:0] ri, input logic [TW-1:0] ti,
                       input logic [DW-1:0] rd, bd);
    bus.in_valid           = v;
    bus.in_write_back_flag = wb;
    bus.in_load_word_flag  = ld;
    bus.in_reg_index       = ri;
    bus.in_thread_index    = ti;
    bus.in_reg_data        = rd;
    bus.in_bram_data       = bd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    bus.stall              = 1'b0;
    bus.flush              = 1'b0;
    bus.flush_thread_index = '0;
`ifdef MEM_PIPE_FORWARD_EN
    bus.fwd_thread_index = '0;
    bus.fwd_reg_index    = '0;
`endif

    //                  in: v  wb ld ri ti  rd           bd              exp: v wb ld ri ti d occ
    vecs[0] = mk(1, 1, 0, 5, 2, 64'hA5,   64'h0,    0, 0, 0, 0, 0, 64'h0,    1);
    vecs[1] = mk(0, 0, 0, 0, 0, 64'h0,    64'h0,    1, 1, 0, 5, 2, 64'hA5,   1);
    vecs[2] = mk(1, 1, 1, 3, 1, 64'hDEAD, 64'hFFFF, 0, 0, 0, 0, 0, 64'h0,    1);
    vecs[3] = mk(0, 0, 0, 0, 0, 64'h0,    64'h1234, 1, 1, 1, 3, 1, 64'h1234, 1);
    vecs[4] = mk(0, 0, 0, 0, 0, 64'h0,    64'hFFFF, 0, 0, 0, 0, 0, 64'h0,    0);
    vecs[5] = mk(1, 0, 0, 1, 0, 64'h11,   64'h0,    0, 0, 0, 0, 0, 64'h0,    1);
    vecs[6] = mk(1, 1, 0, 2, 4, 64'h22,   64'h0,    1, 0, 0, 1, 0, 64'h11,   2);
    vecs[7] = mk(1, 1, 1, 6, 5, 64'h33,   64'h99,   1, 1, 0, 2, 4, 64'h22,   2);
    vecs[8] = mk(0, 0, 0, 0, 0, 64'h0,    64'h4444, 1, 1, 1, 6, 5, 64'h4444, 1);
    vecs[9] = mk(0, 0, 0, 0, 0, 64'h0,    64'h0,    0, 0, 0, 0, 0, 64'h0,    0);

    // Reset state, held across edges, then released mid-cycle
    step();
    step();
    chk_out("reset", 0, 0, 0, 0, 0, 64'h0, 0);
    #3 reset = 1'b0;
    step();
    chk_out("post_reset", 0, 0, 0, 0, 0, 64'h0, 0);

    for (int i = 0; i < int'(NV); i++) begin
      drive(vecs[i].v, vecs[i].wb, vecs[i].ld, vecs[i].ri, vecs[i].ti, vecs[i].rd, vecs[i].bd);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_wb, vecs[i].e_ld, vecs[i].e_ri,
              vecs[i].e_ti, vecs[i].e_d, vecs[i].e_occ);
    end

    // Stall 3 cycles with a load in slot 1; first-stall BRAM word must be delivered once
    drive(1, 1, 1, 4, 6, 64'hBEEF, 64'h0);
    step();
    chk_vo("stl_in", 0, 1);
    drive(1, 1, 0, 9, 6, 64'h99, 64'hAAAA);
    bus.stall = 1'b1;
    step();
    chk_vo("stl_c1", 0, 1);
    bus.in_bram_data = 64'hBBBB;
    step();
    chk_vo("stl_c2", 0, 1);
    bus.in_bram_data = 64'hCCCC;
    step();
    chk_vo("stl_c3", 0, 1);
    bus.stall        = 1'b0;
    bus.in_bram_data = 64'hDDDD;
    step();
    chk_out("stl_load", 1, 1, 1, 4, 6, 64'hAAAA, 2);
    drive(0, 0, 0, 0, 0, 64'h0, 64'hEEEE);
    step();
    chk_out("stl_next", 1, 1, 0, 9, 6, 64'h99, 1);
    step();
    chk_vo("stl_drain", 0, 0);

    // Flush thread 1 during a stall: slot 1 killed, thread 2 in slot 2 held, input dropped
    drive(1, 1, 0, 2, 2, 64'h202, 64'h0);
    step();
    drive(1, 1, 0, 1, 1, 64'h101, 64'h0);
    step();
    chk_out("fl_full", 1, 1, 0, 2, 2, 64'h202, 2);
    drive(1, 1, 0, 3, 1, 64'h303, 64'h0);
    bus.stall              = 1'b1;
    bus.flush              = 1'b1;
    bus.flush_thread_index = 3'd1;
    step();
    chk_out("fl_stall", 1, 1, 0, 2, 2, 64'h202, 1);
    drive(0, 0, 0, 0, 0, 64'h0, 64'h0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    step();
    chk_vo("fl_gone", 0, 0);
    // Flush without stall drops a thread-1 input but passes thread 2 along
    drive(1, 1, 0, 4, 2, 64'h404, 64'h0);
    step();
    drive(1, 1, 0, 3, 1, 64'h303, 64'h0);
    bus.flush = 1'b1;
    step();
    chk_out("fl_pass", 1, 1, 0, 4, 2, 64'h404, 1);
    drive(0, 0, 0, 0, 0, 64'h0, 64'h0);
    bus.flush = 1'b0;
    step();
    chk_vo("fl_drop", 0, 0);

`ifdef MEM_PIPE_FORWARD_EN
    bus.fwd_thread_index = 3'd3;
    bus.fwd_reg_index    = 5'd7;
    drive(1, 1, 0, 7, 3, 64'h77, 64'h0);
    step();
    chk("fwd_alu.hit", DW'(bus.fwd_hit), DW'(1'b1));
    chk("fwd_alu.data", bus.fwd_data, 64'h77);
    drive(1, 1, 1, 7, 3, 64'h0, 64'h0);
    step();
    drive(0, 0, 0, 0, 0, 64'h0, 64'h5555);
    bus.stall = 1'b1;
    #1;
    chk("fwd_pend.hit", DW'(bus.fwd_hit), DW'(1'b0));
    step();
    chk("fwd_cap.hit", DW'(bus.fwd_hit), DW'(1'b1));
    chk("fwd_cap.data", bus.fwd_data, 64'h5555);
    bus.stall = 1'b0;
    step();
    step();
    chk("fwd_empty.hit", DW'(bus.fwd_hit), DW'(1'b0));
    bus.fwd_thread_index = '0;
    bus.fwd_reg_index    = '0;
`endif

    // Async reset between edges with two live slots, then no write-back after release
    drive(1, 1, 0, 1, 0, 64'h1, 64'h0);
    step();
    drive(1, 1, 0, 2, 0, 64'h2, 64'h0);
    step();
    chk_vo("rst_full", 1, 2);
    drive(0, 0, 0, 0, 0, 64'h0, 64'h0);
    #3 reset = 1'b1;
    #1;
    chk_out("rst_async", 0, 0, 0, 0, 0, 64'h0, 0);
    step();
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_after%0d.wb", i), DW'(bus.out_write_back_flag), DW'(1'b0));
      chk_vo($sformatf("rst_after%0d", i), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_pipe_stage_regs.md
# mem_pipe_stage_regs

Parametrised multi-stage pipeline register chain between the MEM1 access stage and write-back in the multithreaded data path. It carries write-back control, destination register and thread index through `STAGES` registered slots, aligns the BRAM read result with its load entry at a configurable BRAM latency, and merges load and ALU results into one write-back data word. It adds per-entry valid, global stall, per-thread flush and an occupancy count.

## Interface
Parameters:
- `DATA_WIDTH`, 64, register and BRAM data width
- `REG_INDEX_BITS`, 5, destination register index width
- `THREAD_INDEX_BITS`, 3, thread index width
- `STAGES`, 2, number of register slots, 1..4
- `BRAM_LATENCY`, 1, BRAM read latency in cycles, 1..`STAGES`

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge
- `reset` in 1: asynchronous, active-high; clears all state immediately
- `in_valid` in 1: entry present at input
- `in_write_back_flag` in 1: entry writes the register file
- `in_load_word_flag` in 1: entry's result comes from BRAM
- `in_reg_index` in `REG_INDEX_BITS`: destination register
- `in_thread_index` in `THREAD_INDEX_BITS`: owning thread
- `in_reg_data` in `DATA_WIDTH`: ALU or store-pass data
- `in_bram_data` in `DATA_WIDTH`: BRAM read port output
- `stall` in 1: hold all slots
- `flush` in 1: kill entries of one thread
- `flush_thread_index` in `THREAD_INDEX_BITS`: thread to kill
- `out_valid` out 1: slot `STAGES` holds a live entry
- `out_write_back_flag` out 1: `out_valid` AND the slot's write-back flag
- `out_load_word_flag`, `out_reg_index`, `out_thread_index` out: slot `STAGES` fields
- `out_wb_data` out `DATA_WIDTH`: write-back data (BRAM data for loads, reg data otherwise)
- `out_occupancy` out `$clog2(STAGES+1)`: number of valid slots

## Operation
- Slots 1..`STAGES`; each holds valid, wb, load, reg index, thread, data, `bram_held`.
- No stall: slot 1 loads the input, slot k loads slot k-1. Stall: all slots hold, and the input is not consumed (upstream must hold).
- BRAM alignment: `in_bram_data` belongs to the entry in slot `BRAM_LATENCY`.
  - If `BRAM_LATENCY` < `STAGES`: when slot `BRAM_LATENCY` advances and is a valid load, the next slot's data field takes `in_bram_data` (or the held copy if `bram_held`), not the reg data.
  - On the first stall cycle with a valid load in slot `BRAM_LATENCY` and `bram_held`=0, capture `in_bram_data` into that slot's data and set `bram_held`. Later BRAM output changes are ignored. `bram_held` clears when the slot advances.
  - If `BRAM_LATENCY`=`STAGES`: `out_wb_data` = load ? (`bram_held` ? held data : `in_bram_data`) : slot data. This path is combinational.
- Flush: every slot whose thread equals `flush_thread_index` has valid cleared at the edge. An input entry of that thread is dropped. Other fields are don't-care.
- Flush with stall: valid clearing applies and the other slots hold.
- `out_occupancy` is the registered popcount of the slot valid bits after the edge.

## Timing
- Reset (async): all valid, `bram_held`, flags, indices and data go to 0. `out_valid`, `out_write_back_flag`, `out_load_word_flag`, `out_occupancy` = 0. `out_wb_data` = 0, except `in_bram_data` is passed through when `BRAM_LATENCY`=`STAGES` and the slot is a load (it is not, after reset).
- Reset released mid-stream: prior entries are lost, with no partial write-back.
- Latency with no stall: `STAGES` cycles from `in_valid` to `out_valid`. Throughput is one entry per cycle.
- A stall of N cycles adds exactly N cycles of latency. No entry is duplicated or dropped.
- All outputs are registered, except `out_wb_data` when `BRAM_LATENCY`=`STAGES`.

## Configuration
- `MEM_PIPE_FORWARD_EN` defined: adds inputs `fwd_thread_index` and `fwd_reg_index`, and outputs `fwd_hit` (1) and `fwd_data` (`DATA_WIDTH`).
  - `fwd_hit`=1 when some valid wb slot matches thread and register and its data is final: a non-load, or a load in a slot > `BRAM_LATENCY`, or a load with `bram_held`.
  - `fwd_data` comes from the youngest (lowest-numbered) matching slot.
  - A matching load whose data is not yet final forces `fwd_hit`=0, even if an older slot matches.
  - Combinational, 0 during reset.
- Undefined: the ports and logic are absent.

## Test plan
- `STAGES`=2, `BRAM_LATENCY`=1; inject wb, non-load, reg 5, thread 2, data 0xA5 -> two cycles later `out_valid`=1, `out_write_back_flag`=1, `out_wb_data`=0xA5, `out_occupancy` 1.
- Load entry, `in_bram_data`=0x1234 in the cycle it sits in slot 1, changed to 0xFFFF afterwards -> output `out_wb_data`=0x1234.
- Same load with `stall` held 3 cycles while the entry is in slot 1 and BRAM changes each cycle -> the first-stall value is delivered 3 cycles late, once.
- Back-to-back threads 1,2,1 with `flush`=1, `flush_thread_index`=1 in the cycle after the third entry enters -> only thread 2 emerges, and `out_occupancy` drops from 2 to 1.
- Assert `reset` asynchronously between clock edges with 2 valid slots -> `out_valid` and `out_occupancy` are 0 before the next edge, and no write-back after release.
- `MEM_PIPE_FORWARD_EN`: query thread 3, reg 7 with a non-load (0x77) in slot 2 and a load in slot 1 before capture -> `fwd_hit`=0. After capture, `fwd_hit`=1 and `fwd_data` = BRAM value.
